// File: rtl/jk_exc_seq_if.sv
// rtl/jk_exc_seq_if.sv - target handshake and JK bank signals for jk_exc_seq
interface jk_exc_seq_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output tgt_valid, tgt, q_fb,
        input  tgt_ready, j, k, busy, done, err
    );

    modport slave (
        input  tgt_valid, tgt, q_fb,
        output tgt_ready, j, k, busy, done, err
    );
endinterface

// File: rtl/jk_exc_seq.sv
// rtl/jk_exc_seq.sv - drives a JK flip-flop bank to a target state with verify and retry
// Define JK_EXC_TOGGLE_EN to drive differing bits with J=K=1 instead of set/reset.
module jk_exc_seq #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input logic          clk,
    input logic          rst,
    jk_exc_seq_if.slave  bus
);
    localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] RETRY_LAST = CW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic [CW-1:0]    retry_cnt;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    // Returns {J, K} for moving the bank from q to t.
    function automatic logic [2*WIDTH-1:0] jk_enc(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] diff;
        diff = q ^ t;
`ifdef JK_EXC_TOGGLE_EN
        return {diff, diff};
`else
        return {diff & t, diff & ~t};
`endif
    endfunction

    // J/K are registered on the edge entering DRIVE, so they are valid for that whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tgt_r     <= '0;
            j_r       <= '0;
            k_r       <= '0;
            retry_cnt <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    j_r <= '0;
                    k_r <= '0;
                    if (bus.tgt_valid) begin
                        tgt_r      <= bus.tgt;
                        retry_cnt  <= '0;
                        {j_r, k_r} <= jk_enc(bus.q_fb, bus.tgt);
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    j_r   <= '0;
                    k_r   <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (bus.q_fb == tgt_r) begin
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end else if (retry_cnt == RETRY_LAST) begin
                        err_r   <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        retry_cnt  <= retry_cnt + 1'b1;
                        {j_r, k_r} <= jk_enc(bus.q_fb, tgt_r);
                        state      <= DRIVE;
                    end
                end
                default: begin
                    j_r     <= '0;
                    k_r     <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.tgt_ready = ready_r;
    assign bus.j         = j_r;
    assign bus.k         = k_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_jk_exc_seq.sv
// tb/tb_jk_exc_seq.sv - scoreboard bench for jk_exc_seq with a behavioural JK bank
module tb_jk_exc_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_exc_seq_if #(.WIDTH(W)) bus ();

    jk_exc_seq #(.WIDTH(W), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] j0;
        logic [W-1:0] k0;
        logic [W-1:0] q_end;
        logic [7:0]   busy_cycles;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int outcomes = 0;

    logic [W-1:0] q;
    logic [W-1:0] load_val = '0;
    logic         load_en  = 1'b1;
    logic         stuck    = 1'b0;

    assign bus.q_fb = q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Flip-flop bank: set, reset, toggle or hold per bit.
    always @(posedge clk) begin
        if (load_en) q <= load_val;
        else if (!stuck) begin
            for (int i = 0; i < W; i++) begin
                case ({bus.j[i], bus.k[i]})
                    2'b10:   q[i] <= 1'b1;
                    2'b01:   q[i] <= 1'b0;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    int           busy_cnt = 0;
    int           viol     = 0;
    logic [W-1:0] first_j, first_k;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
            viol     = 0;
        end else begin
            if (bus.busy) begin
                if (busy_cnt == 0) begin
                    first_j = bus.j;
                    first_k = bus.k;
                end
                if (busy_cnt[0] && (bus.j != '0 || bus.k != '0)) viol++;
                if (bus.tgt_ready) viol++;
                busy_cnt++;
            end
            if (bus.done || bus.err) begin
                if (bus.done && bus.err) viol++;
                if (bus.busy || !bus.tgt_ready) viol++;
                if (sb.size() == 0) check_val("unexpected_outcome", 1, 0);
                else begin
                    e = sb.pop_front();
                    check_val("outcome_err", 32'(bus.err), 32'(e.is_err));
                    check_val("outcome_done", 32'(bus.done), 32'(!e.is_err));
                    check_val("drive_j", 32'(first_j), 32'(e.j0));
                    check_val("drive_k", 32'(first_k), 32'(e.k0));
                    check_val("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
                    check_val("bank_q", 32'(q), 32'(e.q_end));
                    check_val("protocol", 32'(viol), 0);
                end
                busy_cnt = 0;
                viol     = 0;
                outcomes++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic exp_t make_exp(input logic [W-1:0] q0, input logic [W-1:0] t, input bit stk);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            if (q0[i] == t[i]) begin
                e.j0[i] = 1'b0;
                e.k0[i] = 1'b0;
            end else begin
`ifdef JK_EXC_TOGGLE_EN
                e.j0[i] = 1'b1;
                e.k0[i] = 1'b1;
`else
                e.j0[i] = t[i];
                e.k0[i] = q0[i];
`endif
            end
        end
        e.is_err      = stk && (q0 != t);
        e.q_end       = stk ? q0 : t;
        e.busy_cycles = e.is_err ? 8'd8 : 8'd2;
        return e;
    endfunction

    task automatic wait_outcomes(input int target);
        int c = 0;
        while (outcomes < target && c < 60) begin
            step();
            c++;
        end
        if (outcomes < target) check_val("outcome_timeout", 32'(outcomes), 32'(target));
    endtask

    task automatic run_txn(input logic [W-1:0] q0, input logic [W-1:0] t, input bit stk);
        int n;
        n        = outcomes;
        load_val = q0;
        stuck    = stk;
        load_en  = 1'b1;
        step();
        load_en       = 1'b0;
        bus.tgt       = t;
        bus.tgt_valid = 1'b1;
        sb.push_back(make_exp(q0, t, stk));
        step();
        bus.tgt_valid = 1'b0;
        wait_outcomes(n + 1);
    endtask

    initial begin
        int n;
        logic [W-1:0] rq, rt;
        bus.tgt_valid = 1'b0;
        bus.tgt       = '0;
        step();
        step();
        check_val("rst_ready", 32'(bus.tgt_ready), 1);
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_jk", 32'({bus.j, bus.k}), 0);
        check_val("rst_done_err", 32'({bus.done, bus.err}), 0);

        // First acceptance on the first edge after reset release.
        load_en       = 1'b0;
        rst           = 1'b0;
        bus.tgt       = 4'b1010;
        bus.tgt_valid = 1'b1;
        sb.push_back(make_exp(4'b0000, 4'b1010, 1'b0));
        step();
        check_val("first_accept_busy", 32'(bus.busy), 1);
        bus.tgt_valid = 1'b0;
        wait_outcomes(1);

        run_txn(4'b1111, 4'b0101, 1'b0);
        run_txn(4'b0110, 4'b0110, 1'b0);
        run_txn(4'b0000, 4'b0001, 1'b1);
        run_txn(4'b1001, 4'b1001, 1'b1);

        // Target held valid and changed while busy: second target taken only back in IDLE.
        n        = outcomes;
        load_val = 4'b0011;
        stuck    = 1'b0;
        load_en  = 1'b1;
        step();
        load_en       = 1'b0;
        bus.tgt       = 4'b1100;
        bus.tgt_valid = 1'b1;
        sb.push_back(make_exp(4'b0011, 4'b1100, 1'b0));
        sb.push_back(make_exp(4'b1100, 4'b0101, 1'b0));
        step();
        bus.tgt = 4'b0101;
        wait_outcomes(n + 1);
        step();
        bus.tgt_valid = 1'b0;
        wait_outcomes(n + 2);

        // Reset during CHECK aborts with no outcome.
        n        = outcomes;
        load_val = 4'b0000;
        load_en  = 1'b1;
        step();
        load_en       = 1'b0;
        bus.tgt       = 4'b1111;
        bus.tgt_valid = 1'b1;
        step();
        bus.tgt_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check_val("midrst_jk", 32'({bus.j, bus.k}), 0);
        check_val("midrst_busy", 32'(bus.busy), 0);
        check_val("midrst_ready", 32'(bus.tgt_ready), 1);
        check_val("midrst_done_err", 32'({bus.done, bus.err}), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("midrst_no_outcome", 32'(outcomes), 32'(n));

        for (int i = 0; i < 6; i++) begin
            rq = W'($urandom_range(0, 15));
            rt = W'($urandom_range(0, 15));
            run_txn(rq, rt, (i % 3) == 2);
        end

        for (int i = 0; i < 3; i++) step();
        check_val("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jk_exc_seq.md
JK_EXC_SEQ -- requirements
Module: jk_exc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of driven JK flip-flops.
REQ-002 SHALL have parameter MAX_RETRY, default 3, giving the number of re-drive attempts before the error flag.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port TGT_VALID, input, 1 bit: the target word is valid.
REQ-006 SHALL have port TGT, input, WIDTH bits: the target flip-flop state.
REQ-007 SHALL have port TGT_READY, output, 1 bit: the block accepts a target.
REQ-008 SHALL have port Q_FB, input, WIDTH bits: Q outputs fed back from the driven flip-flop bank.
REQ-009 SHALL have port J, output, WIDTH bits: J inputs of the bank.
REQ-010 SHALL have port K, output, WIDTH bits: K inputs of the bank.
REQ-011 SHALL have port BUSY, output, 1 bit: a sequence is in progress.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle pulse when Q_FB matches the target.
REQ-013 SHALL have port ERR, output, 1 bit: one-cycle pulse when retries are exhausted.

Function
REQ-014 SHALL implement the FSM states IDLE, DRIVE and CHECK; all outputs SHALL be registered.
REQ-015 In IDLE, the block SHALL drive TGT_READY=1, BUSY=0, J=0 and K=0.
REQ-016 On TGT_VALID&&TGT_READY, the block SHALL capture TGT into tgt_r, clear retry_cnt and enter DRIVE.
REQ-017 In DRIVE (exactly one cycle), the block SHALL drive J/K per bit from Q_FB versus tgt_r:
- equal bits: J=0, K=0 (hold);
- Q=0, target=1: J=1, K=0;
- Q=1, target=0: J=0, K=1.
The block SHALL then enter CHECK.
REQ-018 In CHECK, the block SHALL force J=0 and K=0 and compare Q_FB with tgt_r. The bank updated on the edge ending DRIVE, so Q_FB is expected to be settled.
REQ-019 If the CHECK comparison matches, the block SHALL pulse DONE for that cycle and return to IDLE.
REQ-020 If the CHECK comparison mismatches and retry_cnt<MAX_RETRY, the block SHALL increment retry_cnt and return to DRIVE.
REQ-021 If the CHECK comparison mismatches and retry_cnt==MAX_RETRY, the block SHALL pulse ERR and return to IDLE.
REQ-022 Nominal latency SHALL be: accept edge -> DRIVE cycle -> CHECK cycle with DONE, i.e. DONE asserted in the 2nd cycle after acceptance.
REQ-023 A target equal to the current Q_FB SHALL still traverse DRIVE (J=K=0) and CHECK, and SHALL produce DONE at the same latency.
REQ-024 TGT_READY SHALL be 0 outside IDLE, and TGT_VALID SHALL be ignored while BUSY=1.
REQ-025 BUSY SHALL be 1 in DRIVE and CHECK, and DONE and ERR SHALL never be asserted together.
REQ-026 retry_cnt SHALL be sized ceil(log2(MAX_RETRY+1)) bits and SHALL never wrap.
REQ-027 MAX_RETRY=0 SHALL give a single drive attempt followed by DONE or ERR.

Reset
REQ-028 On RST=1, asynchronously and in any state: state=IDLE, J=0, K=0, TGT_READY=1, BUSY=0, DONE=0, ERR=0, tgt_r=0, retry_cnt=0.
REQ-029 Reset asserted mid-sequence SHALL abort it with no DONE or ERR pulse.
REQ-030 The first acceptance SHALL be possible on the first rising edge after RST deasserts.

Configuration
REQ-031 The macro JK_EXC_TOGGLE_EN SHALL select the DRIVE encoding:
- when defined, differing bits SHALL be driven with J=1, K=1 (toggle) and equal bits with J=0, K=0;
- when undefined, the set/reset encoding of REQ-017 SHALL be used.
REQ-032 FSM, latency and handshake SHALL be identical in both configurations.

Verification
REQ-033 WIDTH=4: Q_FB=0000, accept TGT=1010, model bank updates -> DRIVE J=1010 K=0000; next cycle DONE=1, BUSY=0 after.
REQ-034 Q_FB=1111, TGT=0101 -> DRIVE J=0000 K=1010 (undefined macro) or J=1010 K=1010 (JK_EXC_TOGGLE_EN); DONE in 2nd cycle.
REQ-035 Q_FB stuck at 0000, TGT=0001, MAX_RETRY=3 -> 4 DRIVE cycles alternating with CHECK, then ERR=1 for one cycle, DONE never 1.
REQ-036 TGT=Q_FB=0110 -> J=K=0000 throughout, DONE in 2nd cycle.
REQ-037 TGT_VALID held high with a new TGT during DRIVE/CHECK -> TGT_READY=0, tgt_r unchanged; new target accepted only after return to IDLE.
REQ-038 RST pulsed during CHECK -> immediately J=K=0, BUSY=0, TGT_READY=1, no DONE/ERR.
